// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: prescaled tick drives a ripple of BCD digits under an IDLE/RUN/PAUSE/DONE FSM.
// Count moves one edge after a tick; done/wrap are registered one-cycle pulses; controls are level-sampled, no backpressure.
module bcd_stopwatch_ctrl #(
   parameter int unsigned PRESCALE = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic [15:0] limit,
   output logic [15:0] count,
   output logic [3:0]  digit_en,
   output logic [1:0]  state,
   output logic        done,
   output logic        wrap
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   state_t      state_q, state_d;
   logic [15:0] presc_q, presc_d;
   logic [15:0] count_q, count_d;
   logic        done_q, done_d;
   logic        wrap_q, wrap_d;

   logic        run;
   logic        at_last;
   logic        tick;
   logic [3:0]  nine;
   logic [3:0]  den;
   logic        all_nine;
   logic [15:0] count_inc;
   logic        limit_valid;
   logic        limit_hit;

   // Tick, ripple enables and the candidate incremented count.
   always_comb begin
      run       = (state_q == ST_RUN);
      at_last   = (presc_q == PS_LAST);
      tick      = run && at_last && !stop && !clear;
      nine      = '0;
      count_inc = count_q;
      for (int i = 0; i < 4; i++) begin
         nine[i] = (count_q[4*i +: 4] == 4'd9);
      end
      den[0]   = tick;
      den[1]   = tick & nine[0];
      den[2]   = tick & (&nine[1:0]);
      den[3]   = tick & (&nine[2:0]);
      all_nine = &nine;
      for (int i = 0; i < 4; i++) begin
         if (den[i]) begin
            count_inc[4*i +: 4] = nine[i] ? 4'd0 : count_q[4*i +: 4] + 4'd1;
         end
      end
      // A limit with any non-decimal nibble can never equal a BCD count.
      limit_valid = (limit != 16'h0000) &&
                    (limit[3:0]   <= 4'd9) && (limit[7:4]   <= 4'd9) &&
                    (limit[11:8]  <= 4'd9) && (limit[15:12] <= 4'd9);
      limit_hit   = tick && limit_valid && (count_inc == limit);
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (!stop && start) begin
               state_d = ST_RUN;
               presc_d = '0;
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_d = ST_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (stop) begin
               // Prescaler keeps running unless this was the would-be tick.
               state_d = ST_PAUSE;
               if (!at_last) begin
                  presc_d = presc_q + 16'd1;
               end
            end else begin
               presc_d = at_last ? 16'd0 : presc_q + 16'd1;
               count_d = count_inc;
               wrap_d  = tick && all_nine;
               if (limit_hit) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_PAUSE: begin
            if (clear) begin
               state_d = ST_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (!stop && start) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (clear) begin
               state_d = ST_IDLE;
               count_d = '0;
               presc_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count    = count_q;
   assign digit_en = den;
   assign state    = state_q;
   assign done     = done_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: two instances (PRESCALE 2 and 4) share stimulus and are
// checked every cycle against a decimal-arithmetic model, plus directed literal checks.
module tb_bcd_stopwatch_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, stop, clear;
   logic [15:0] limit;
   logic [15:0] count2, count4;
   logic [3:0]  den2, den4;
   logic [1:0]  st2, st4;
   logic        done2, done4, wrap2, wrap4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_stopwatch_ctrl #(.PRESCALE(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .limit(limit),
      .count(count2), .digit_en(den2), .state(st2), .done(done2), .wrap(wrap2)
   );

   bcd_stopwatch_ctrl #(.PRESCALE(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .limit(limit),
      .count(count4), .digit_en(den4), .state(st4), .done(done4), .wrap(wrap4)
   );

   // Model: count as a plain integer 0..9999, state as IDLE=0 RUN=1 PAUSE=2 DONE=3.
   int m_st[2];
   int m_cnt[2];
   int m_pre[2];
   bit m_done[2];
   bit m_wrap[2];

   function automatic int ps(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int lim_val(input logic [15:0] l);
      int v;
      v = 0;
      for (int i = 3; i >= 0; i--) begin
         if (l[4*i +: 4] > 4'd9) return -1;
         v = v * 10 + int'(l[4*i +: 4]);
      end
      return (v == 0) ? -1 : v;
   endfunction

   function automatic bit m_tick(input int k);
      return (m_st[k] == 1) && (m_pre[k] == ps(k) - 1) && !stop && !clear;
   endfunction

   function automatic logic [3:0] m_den(input int k);
      logic [3:0] e;
      int pw;
      e  = '0;
      pw = 1;
      if (m_tick(k)) begin
         for (int i = 0; i < 4; i++) begin
            e[i] = (m_cnt[k] % pw == pw - 1);
            pw   = pw * 10;
         end
      end
      return e;
   endfunction

   task automatic m_step(input int k);
      int st, pre, cnt, lv;
      bit tk;
      st = m_st[k]; pre = m_pre[k]; cnt = m_cnt[k];
      tk = m_tick(k);
      lv = lim_val(limit);
      m_done[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (clear) begin
         st = 0; cnt = 0; pre = 0;
      end else begin
         case (st)
            0: if (start && !stop) begin st = 1; pre = 0; end
            1: begin
               if (tk) begin
                  cnt = (cnt + 1) % 10000;
                  pre = 0;
                  m_wrap[k] = (cnt == 0);
                  if (cnt == lv) begin st = 3; m_done[k] = 1'b1; end
               end else if (pre != ps(k) - 1) begin
                  pre = pre + 1;
               end
               if (stop) st = 2;
            end
            2: if (start && !stop) st = 1;
            default: ;
         endcase
      end
      m_st[k] = st; m_pre[k] = pre; m_cnt[k] = cnt;
   endtask

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_st[k] = 0; m_cnt[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0; m_wrap[k] = 1'b0;
         end else begin
            m_step(k);
         end
      end
   end

   task automatic cmp(input int k, input logic [15:0] c, input logic [1:0] s,
                      input logic [3:0] e, input logic d, input logic w);
      logic [15:0] ec;
      logic [3:0]  ee;
      ec = to_bcd(m_cnt[k]);
      ee = m_den(k);
      total++;
      if (c !== ec || s !== 2'(m_st[k]) || e !== ee || d !== m_done[k] || w !== m_wrap[k]) begin
         bad++;
         $display("FAIL model_cmp dut_p%0d t=%0t got cnt=%h st=%0d en=%b done=%b wrap=%b want cnt=%h st=%0d en=%b done=%b wrap=%b",
                  ps(k), $time, c, s, e, d, w, ec, m_st[k], ee, m_done[k], m_wrap[k]);
      end
   endtask

   always @(negedge clk) begin
      cmp(0, count2, st2, den2, done2, wrap2);
      cmp(1, count4, st4, den4, done4, wrap4);
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; limit = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_count", count2, 16'h0000);
      chk("rst_state", 16'(st2), 16'h0000);
      chk("rst_den", 16'(den2), 16'h0000);
      reset = 1'b0;

      // Limit 12 at PRESCALE 2: DONE lands on the 24th edge after RUN entry.
      limit = 16'h0012; start = 1'b1; step(); start = 1'b0;
      chk("run_entry_state", 16'(st2), 16'd1);
      step(); chk("p2_edge1", count2, 16'h0000);
      step(); chk("p2_edge2", count2, 16'h0001);
      repeat (21) step();
      chk("edge23_count", count2, 16'h0011);
      chk("edge23_done", 16'(done2), 16'd0);
      step();
      chk("edge24_done", 16'(done2), 16'd1);
      chk("edge24_state", 16'(st2), 16'd3);
      chk("edge24_count", count2, 16'h0012);
      step();
      chk("edge25_done", 16'(done2), 16'd0);
      chk("edge25_state", 16'(st2), 16'd3);

      // DONE ignores start; clear returns to IDLE.
      start = 1'b1;
      repeat (5) begin
         step();
         chk("done_hold_state", 16'(st2), 16'd3);
         chk("done_no_repulse", 16'(done2), 16'd0);
      end
      start = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;
      chk("done_clear_state", 16'(st2), 16'd0);
      chk("done_clear_count", count2, 16'h0000);

      // Free-run: ripple into digit 2, then full wrap.
      limit = 16'h0000; start = 1'b1; step(); start = 1'b0;
      n = 0; while (count2 != 16'h0099 && n < 400) begin step(); n++; end
      chk("reach_0099", count2, 16'h0099);
      n = 0; while (den2 == 4'd0 && n < 4) begin step(); n++; end
      chk("den_at_0099", 16'(den2), 16'b0111);
      step(); chk("count_0100", count2, 16'h0100);
      n = 0; while (count2 != 16'h9999 && n < 25000) begin step(); n++; end
      chk("reach_9999", count2, 16'h9999);
      n = 0; while (den2 == 4'd0 && n < 4) begin step(); n++; end
      chk("den_at_9999", 16'(den2), 16'b1111);
      step();
      chk("wrap_count", count2, 16'h0000);
      chk("wrap_pulse", 16'(wrap2), 16'd1);
      step();
      chk("wrap_gone", 16'(wrap2), 16'd0);

      // PRESCALE 4: pause right after a tick, resume mid-period.
      clear = 1'b1; step(); clear = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      n = 0; while (den4 == 4'd0 && n < 8) begin step(); n++; end
      chk("p4_first_en", 16'(den4), 16'b0001);
      step(); chk("p4_first_inc", count4, 16'h0001);
      stop = 1'b1; step(); stop = 1'b0;
      chk("pause_state", 16'(st4), 16'd2);
      repeat (10) begin
         step();
         chk("pause_hold_count", count4, 16'h0001);
      end
      start = 1'b1; step(); start = 1'b0;
      chk("resume_state", 16'(st4), 16'd1);
      step(); step();
      chk("resume_plus2", count4, 16'h0001);
      step();
      chk("resume_plus3", count4, 16'h0002);

      // Stop on a tick cycle suppresses it; clear beats start in PAUSE.
      n = 0; while (den4 == 4'd0 && n < 8) begin step(); n++; end
      stop = 1'b1; #1;
      chk("stop_kills_en", 16'(den4), 16'h0000);
      step(); stop = 1'b0;
      chk("stop_tick_state", 16'(st4), 16'd2);
      chk("stop_tick_count", count4, 16'h0002);
      clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
      chk("clr_start_state", 16'(st4), 16'd0);
      chk("clr_start_count", count4, 16'h0000);

      // Asynchronous reset between edges while running.
      start = 1'b1; step(); start = 1'b0;
      n = 0; while (count2 != 16'h0037 && n < 200) begin step(); n++; end
      chk("reach_0037", count2, 16'h0037);
      reset = 1'b1; #1;
      chk("async_rst_count", count2, 16'h0000);
      chk("async_rst_state", 16'(st2), 16'd0);
      reset = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      chk("post_rst_run", 16'(st2), 16'd1);
      step(); chk("post_rst_edge1", count2, 16'h0000);
      step(); chk("post_rst_edge2", count2, 16'h0001);

      // Randomized traffic against the model.
      for (int c = 0; c < 6000; c++) begin
         start = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 15) == 0);
         clear = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 5))
               0: limit = 16'h0000;
               1: limit = 16'h0003;
               2: limit = 16'h0011;
               3: limit = 16'h00A5;
               4: limit = to_bcd(int'($urandom_range(1, 40)));
               default: limit = 16'h001F;
            endcase
         end
         if ($urandom_range(0, 699) == 0) begin
            reset = 1'b1; #2; reset = 1'b0;
         end
         step();
      end
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
